program_loader: RTL

Loads a program image into the instruction memory that the program counter later reads. Consumes a byte stream over a valid/ready handshake (e.g. from a UART receiver), assembles 16-bit instruction words, and writes them to sequential instruction-memory addresses starting at 0. Holds the CPU off until loading completes, then releases it.

---
 rtl/program_loader_pkg.sv | 39 +++
 rtl/program_loader_byte_pair_assembler.sv | 48 ++++
 rtl/program_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader: FSM state encoding, stream
// framing constants, default widths and the header-limit helper.
package program_loader_pkg;

    localparam int BITS_ADDRESS_DEFAULT = 11;
    localparam int BITS_DATA_DEFAULT    = 16;
    localparam int HEADER_BYTES         = 2;
    localparam int BYTES_PER_WORD       = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_HI  = 3'd1,
        ST_CNT_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_e;

    // True when the header word count does not fit in a memory of
    // 2**bits_address words. A count equal to the depth is still legal.
    function automatic logic count_exceeds(input logic [15:0] n, input int bits_address);
        logic [31:0] depth;
        depth = 32'd1 << bits_address;
        return (32'(n) > depth);
    endfunction

    // States in which the loader takes bytes from the stream.
    function automatic logic is_receiving(input state_e s);
        logic r;
        case (s)
            ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/program_loader_byte_pair_assembler.sv
// program_loader_byte_pair_assembler
// Combines two consecutive stream bytes (high byte first) into one 16-bit
// word. The high byte is latched; when the low byte is accepted the full
// word is presented together with a one-cycle strobe.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear of the latched high byte
//   byte_valid   a byte is accepted this cycle
//   low_byte     the accepted byte is the low half of a word
//   byte_in      accepted byte
//   word         {latched high byte, byte_in}
//   word_valid   word is complete this cycle
module program_loader_byte_pair_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic        low_byte,
    input  logic [7:0]  byte_in,
    output logic [15:0] word,
    output logic        word_valid
);

    logic [7:0] hi_r;

    // High-byte holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 8'd0;
        end else if (clear) begin
            hi_r <= 8'd0;
        end else if (byte_valid && !low_byte) begin
            hi_r <= byte_in;
        end else begin
            hi_r <= hi_r;
        end
    end

    // Word is formed combinationally so the consumer can register it on the
    // same edge that accepts the low byte.
    always_comb begin
        word       = {hi_r, byte_in};
        word_valid = byte_valid && low_byte;
    end

endmodule

// File: rtl/program_loader.sv
// program_loader
// Streams a program image into instruction memory. The byte stream carries a
// 2-byte word count N followed by N 16-bit words, all high byte first. Words
// are written to addresses 0..N-1. The CPU is held until the load completes;
// an oversize header parks the loader in an error state with the CPU held.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse starting a load session
//   rx_data/rx_valid/rx_ready  byte stream handshake
//   mem_we/mem_addr/mem_wdata  instruction-memory write port
//   cpu_hold      keeps the CPU stalled while high
//   done, error   session status levels
//   words_loaded  words written in the current or last session
module program_loader
    import program_loader_pkg::*;
#(
    parameter int bits_address = BITS_ADDRESS_DEFAULT,
    parameter int bits_data    = BITS_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    mem_we,
    output logic [bits_address-1:0] mem_addr,
    output logic [bits_data-1:0]    mem_wdata,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [bits_address:0]   words_loaded
);

    state_e                  state_r;
    state_e                  next_state_s;

    logic                    rx_ready_r;
    logic                    mem_we_r;
    logic [bits_address-1:0] mem_addr_r;
    logic [bits_data-1:0]    mem_wdata_r;
    logic                    cpu_hold_r;
    logic                    done_r;
    logic                    error_r;
    logic [bits_address:0]   words_r;
    logic [15:0]             count_r;

    logic                    rx_ready_nxt_s;
    logic                    cpu_hold_nxt_s;
    logic                    done_nxt_s;
    logic                    error_nxt_s;
    logic                    mem_we_nxt_s;

    logic                    acc_s;
    logic                    low_byte_s;
    logic                    start_ok_s;
    logic [15:0]             word_s;
    logic                    word_valid_s;
    logic                    hdr_word_s;
    logic                    data_word_s;
    logic [bits_address:0]   words_inc_s;
    logic                    last_word_s;

    // Handshake and datapath qualifiers derived from the current state.
    always_comb begin
        acc_s       = rx_valid && rx_ready_r;
        low_byte_s  = (state_r == ST_CNT_LO) || (state_r == ST_DATA_LO);
        start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                (state_r == ST_ERROR));
        hdr_word_s  = word_valid_s && (state_r == ST_CNT_LO);
        data_word_s = word_valid_s && (state_r == ST_DATA_LO);
        words_inc_s = words_r + {{bits_address{1'b0}}, 1'b1};
        last_word_s = (32'(words_inc_s) == 32'(count_r));
    end

    program_loader_byte_pair_assembler u_pair (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_ok_s),
        .byte_valid (acc_s),
        .low_byte   (low_byte_s),
        .byte_in    (rx_data),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; the header decision uses the freshly assembled
    // word since count_r is only loaded on the same edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    next_state_s = ST_CNT_HI;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CNT_HI: begin
                if (acc_s) begin
                    next_state_s = ST_CNT_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_CNT_LO: begin
                if (!hdr_word_s) begin
                    next_state_s = state_r;
                end else if (word_s == 16'd0) begin
                    next_state_s = ST_DONE;
                end else if (count_exceeds(word_s, bits_address)) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (acc_s) begin
                    next_state_s = ST_DATA_LO;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DATA_LO: begin
                if (!data_word_s) begin
                    next_state_s = state_r;
                end else if (last_word_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DATA_HI;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the next state, so the registered outputs line
    // up with the state they describe.
    always_comb begin
        rx_ready_nxt_s = is_receiving(next_state_s);
        done_nxt_s     = (next_state_s == ST_DONE);
        error_nxt_s    = (next_state_s == ST_ERROR);
        cpu_hold_nxt_s = (next_state_s != ST_DONE);
        mem_we_nxt_s   = data_word_s;
    end

    // Registered control and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_r <= 1'b0;
            mem_we_r   <= 1'b0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rx_ready_r <= rx_ready_nxt_s;
            mem_we_r   <= mem_we_nxt_s;
            cpu_hold_r <= cpu_hold_nxt_s;
            done_r     <= done_nxt_s;
            error_r    <= error_nxt_s;
        end
    end

    // Memory write address/data stage; holds its last value between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_r  <= {bits_address{1'b0}};
            mem_wdata_r <= {bits_data{1'b0}};
        end else if (data_word_s) begin
            mem_addr_r  <= words_r[bits_address-1:0];
            mem_wdata_r <= word_s;
        end else begin
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // Word counter; it doubles as the write address, and the header limit
    // keeps it from exceeding the memory depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_r <= {(bits_address+1){1'b0}};
        end else if (start_ok_s) begin
            words_r <= {(bits_address+1){1'b0}};
        end else if (data_word_s) begin
            words_r <= words_inc_s;
        end else begin
            words_r <= words_r;
        end
    end

    // Header word count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'd0;
        end else if (hdr_word_s) begin
            count_r <= word_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign rx_ready     = rx_ready_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_r;

endmodule
